masked_mul_scheduler: RTL and testbench

Round-robin scheduler that shares one masked HPC1 multiplier instance among NUM_REQ requesters.
- Issues at most one multiplication per cycle.
- Aligns operand and randomness timing to the multiplier's two internal stages: b and r at stage 0, a and p at stage 1.
- Tags each result with its requester id.
- Sits between the S-box/key-schedule masked-product consumers and a single shared multiplier plus fresh-randomness source.

---
 rtl/masked_mul_scheduler_pkg.sv | 14 +
 rtl/masked_mul_scheduler_if.sv | 49 ++++
 rtl/masked_mul_scheduler_arbiter.sv | 52 +++++
 rtl/masked_mul_scheduler.sv | 99 +++++++++
 tb/tb_masked_mul_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/masked_mul_scheduler_pkg.sv
// Shared sizing helpers for the masked multiplier scheduler and its arbiter.
// Pure functions only; no state.
package masked_mul_scheduler_pkg;

  // Number of cross-term masks an HPC1 multiplier needs for n shares.
  function automatic int num_quad(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/masked_mul_scheduler_if.sv
// Requester, randomness, multiplier and result buses of the scheduler.
// master = scheduler side, slave = environment side.
interface masked_mul_scheduler_if
  import masked_mul_scheduler_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 1,
  parameter int NUM_REQ    = 4
);
  localparam int SW   = NUM_SHARES * BIT_WIDTH;
  localparam int PW   = num_quad(NUM_SHARES) * BIT_WIDTH;
  localparam int ID_W = id_width(NUM_REQ);

  logic                    in_enable;
  logic [NUM_REQ-1:0]      in_req_valid;
  logic [NUM_REQ*SW-1:0]   in_req_a;
  logic [NUM_REQ*SW-1:0]   in_req_b;
  logic [NUM_REQ-1:0]      out_req_ready;
  logic                    in_rand_valid;
  logic [SW-1:0]           in_rand_r;
  logic [PW-1:0]           in_rand_p;
  logic                    out_rand_ready;
  logic [SW-1:0]           out_mul_a;
  logic [SW-1:0]           out_mul_b;
  logic [SW-1:0]           out_mul_r;
  logic [PW-1:0]           out_mul_p;
  logic [SW-1:0]           in_mul_c;
  logic                    out_res_valid;
  logic [ID_W-1:0]         out_res_id;
  logic [SW-1:0]           out_res_c;
  logic                    out_busy;

  modport master (
    input  in_enable, in_req_valid, in_req_a, in_req_b,
    input  in_rand_valid, in_rand_r, in_rand_p, in_mul_c,
    output out_req_ready, out_rand_ready,
    output out_mul_a, out_mul_b, out_mul_r, out_mul_p,
    output out_res_valid, out_res_id, out_res_c, out_busy
  );

  modport slave (
    output in_enable, in_req_valid, in_req_a, in_req_b,
    output in_rand_valid, in_rand_r, in_rand_p, in_mul_c,
    input  out_req_ready, out_rand_ready,
    input  out_mul_a, out_mul_b, out_mul_r, out_mul_p,
    input  out_res_valid, out_res_id, out_res_c, out_busy
  );

endinterface

// File: rtl/masked_mul_scheduler_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer holds last winner.
// Zero latency; pointer advances only when the grant is actually taken.
module round_robin_arbiter
  import masked_mul_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic               in_clock,
  input  logic               in_reset,
  input  logic [NUM_REQ-1:0] in_req,
  input  logic               in_advance,
  output logic [NUM_REQ-1:0] out_grant,
  output logic [ID_W-1:0]    out_grant_idx
);

  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_hi_mask;
  logic [NUM_REQ-1:0] w_req_hi;
  logic [NUM_REQ-1:0] w_pick;

  // Requests above the pointer take priority; otherwise wrap to the lowest index.
  always_comb begin
    w_hi_mask = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_hi_mask[j] = (j > int'(r_ptr));
    end
    w_req_hi = in_req & w_hi_mask;
    w_pick   = (|w_req_hi) ? w_req_hi : in_req;
  end

  always_comb begin
    out_grant     = '0;
    out_grant_idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_pick[j]) begin
        out_grant     = '0;
        out_grant[j]  = 1'b1;
        out_grant_idx = ID_W'(j);
      end
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (in_advance && (|in_req)) begin
      r_ptr <= out_grant_idx;
    end
  end

endmodule

// File: rtl/masked_mul_scheduler.sv
// Shares one HPC1 masked multiplier among NUM_REQ requesters, one issue per cycle,
// result 2 cycles after handshake; no result backpressure, issue stalls on enable/randomness.
module masked_mul_scheduler
  import masked_mul_scheduler_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 1,
  parameter int NUM_REQ    = 4
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  masked_mul_scheduler_if.master bus
);

  localparam int SW   = NUM_SHARES * BIT_WIDTH;
  localparam int PW   = num_quad(NUM_SHARES) * BIT_WIDTH;
  localparam int ID_W = id_width(NUM_REQ);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic               w_issue;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic [SW-1:0]      w_sel_a;
  logic [SW-1:0]      w_sel_b;

  logic               r_s1_vld;
  logic [ID_W-1:0]    r_s1_id;
  logic [SW-1:0]      r_s1_a;
  logic [PW-1:0]      r_s1_p;
  logic               r_s2_vld;
  logic [ID_W-1:0]    r_s2_id;

  // Reset asserts immediately, releases two clock edges later.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];
  assign w_issue = w_rst_n & bus.in_enable & bus.in_rand_valid & (|bus.in_req_valid);

  round_robin_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .in_clock      (in_clock),
    .in_reset      (w_rst_n),
    .in_req        (bus.in_req_valid),
    .in_advance    (w_issue),
    .out_grant     (w_grant),
    .out_grant_idx (w_grant_idx)
  );

  // One-hot AND-OR select so only the winner's shares ever reach the multiplier.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_sel_a = w_sel_a | bus.in_req_a[j*SW +: SW];
        w_sel_b = w_sel_b | bus.in_req_b[j*SW +: SW];
      end
    end
  end

  assign bus.out_req_ready  = {NUM_REQ{w_issue}} & w_grant;
  assign bus.out_rand_ready = w_issue;
  assign bus.out_mul_b      = w_issue ? w_sel_b : '0;
  assign bus.out_mul_r      = w_issue ? bus.in_rand_r : '0;

  always_ff @(posedge in_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_id  <= '0;
      r_s1_a   <= '0;
      r_s1_p   <= '0;
      r_s2_vld <= 1'b0;
      r_s2_id  <= '0;
    end else begin
      r_s1_vld <= w_issue;
      r_s1_id  <= w_issue ? w_grant_idx : '0;
      r_s1_a   <= w_issue ? w_sel_a : '0;
      r_s1_p   <= w_issue ? bus.in_rand_p : '0;
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_vld ? r_s1_id : '0;
    end
  end

  assign bus.out_mul_a     = r_s1_a;
  assign bus.out_mul_p     = r_s1_p;
  assign bus.out_res_valid = r_s2_vld;
  assign bus.out_res_id    = r_s2_id;
  assign bus.out_res_c     = r_s2_vld ? bus.in_mul_c : '0;
  assign bus.out_busy      = r_s1_vld | r_s2_vld;

endmodule

// File: tb/tb_masked_mul_scheduler.sv
// Directed and randomized checks of masked_mul_scheduler with a 2-share HPC1 multiplier model.
module tb_masked_mul_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  masked_mul_scheduler_if #(.NUM_SHARES(2), .BIT_WIDTH(1), .NUM_REQ(4)) bus ();

  masked_mul_scheduler #(
    .NUM_SHARES (2),
    .BIT_WIDTH  (1),
    .NUM_REQ    (4)
  ) dut (
    .in_clock (clk),
    .in_reset (rst_n),
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // HPC1 multiplier, 2 shares: refresh b with r at stage 0, DOM products with p at stage 1.
  logic m_rb0, m_rb1, m_q00, m_q11, m_u01, m_u10;
  always @(posedge clk) begin
    m_rb0 <= bus.out_mul_b[0] ^ bus.out_mul_r[0] ^ bus.out_mul_r[1];
    m_rb1 <= bus.out_mul_b[1] ^ bus.out_mul_r[1] ^ bus.out_mul_r[0];
    m_q00 <= bus.out_mul_a[0] & m_rb0;
    m_q11 <= bus.out_mul_a[1] & m_rb1;
    m_u01 <= (bus.out_mul_a[0] & m_rb1) ^ bus.out_mul_p[0];
    m_u10 <= (bus.out_mul_a[1] & m_rb0) ^ bus.out_mul_p[0];
  end
  assign bus.in_mul_c = {m_q11 ^ m_u10, m_q00 ^ m_u01};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_enable     = 1'b1;
    bus.in_req_valid  = 4'd0;
    bus.in_req_a      = 8'd0;
    bus.in_req_b      = 8'd0;
    bus.in_rand_valid = 1'b0;
    bus.in_rand_r     = 2'd0;
    bus.in_rand_p     = 1'b0;
  endtask

  // One isolated request from requester g; other slots carry all-ones shares.
  task automatic single(input int g, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] r, input logic p, input logic ec);
    logic [3:0] oh;
    oh = 4'(32'd1 << g);
    bus.in_enable     = 1'b1;
    bus.in_req_valid  = oh;
    bus.in_req_a      = ~(8'd3 << (2*g)) | (8'(a) << (2*g));
    bus.in_req_b      = ~(8'd3 << (2*g)) | (8'(b) << (2*g));
    bus.in_rand_valid = 1'b1;
    bus.in_rand_r     = r;
    bus.in_rand_p     = p;
    #1;
    chk("single_ready", 32'(bus.out_req_ready), 32'(oh));
    chk("single_rand_ready", 32'(bus.out_rand_ready), 32'd1);
    chk("single_mul_b", 32'(bus.out_mul_b), 32'(b));
    chk("single_mul_r", 32'(bus.out_mul_r), 32'(r));
    cyc();
    idle_in();
    #1;
    chk("single_mul_a", 32'(bus.out_mul_a), 32'(a));
    chk("single_mul_p", 32'(bus.out_mul_p), 32'(p));
    chk("single_busy_s1", 32'(bus.out_busy), 32'd1);
    chk("single_res_early", 32'(bus.out_res_valid), 32'd0);
    cyc();
    #1;
    chk("single_res_valid", 32'(bus.out_res_valid), 32'd1);
    chk("single_res_id", 32'(bus.out_res_id), 32'(g));
    chk("single_res_c", 32'(^bus.out_res_c), 32'(ec));
    cyc();
    #1;
    chk("single_res_after", 32'(bus.out_res_valid), 32'd0);
    chk("single_busy_after", 32'(bus.out_busy), 32'd0);
    cyc();
  endtask

  // Random-phase scoreboard: p1 = issued last cycle, p2 = issued two cycles ago.
  int   mptr;
  int   n_ops;
  logic p1_v, p2_v, p1_c, p2_c;
  int   p1_id, p2_id;

  task automatic rand_cycle(input bit quiet);
    logic [3:0] v;
    logic       en, rv, iss, found;
    logic [7:0] a, b;
    logic [1:0] r;
    logic       p;
    int         g, idx;
    v  = quiet ? 4'd0 : 4'($urandom);
    en = ($urandom_range(0, 7) != 0);
    rv = ($urandom_range(0, 3) != 0);
    a  = 8'($urandom);
    b  = 8'($urandom);
    r  = 2'($urandom);
    p  = 1'($urandom);
    bus.in_enable     = en;
    bus.in_req_valid  = v;
    bus.in_req_a      = a;
    bus.in_req_b      = b;
    bus.in_rand_valid = rv;
    bus.in_rand_r     = r;
    bus.in_rand_p     = p;
    #1;
    iss   = en & rv & (|v);
    g     = 0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = (mptr + k) % 4;
      if (!found && (((v >> idx) & 4'd1) != 4'd0)) begin
        found = 1'b1;
        g     = idx;
      end
    end
    chk("rnd_ready", 32'(bus.out_req_ready), iss ? (32'd1 << g) : 32'd0);
    chk("rnd_rand_ready", 32'(bus.out_rand_ready), 32'(iss));
    chk("rnd_mul_b", 32'(bus.out_mul_b), iss ? 32'((b >> (2*g)) & 8'd3) : 32'd0);
    chk("rnd_mul_r", 32'(bus.out_mul_r), iss ? 32'(r) : 32'd0);
    chk("rnd_res_valid", 32'(bus.out_res_valid), 32'(p2_v));
    if (p2_v) begin
      chk("rnd_res_id", 32'(bus.out_res_id), 32'(p2_id));
      chk("rnd_res_c", 32'(^bus.out_res_c), 32'(p2_c));
    end
    p2_v  = p1_v;
    p2_id = p1_id;
    p2_c  = p1_c;
    p1_v  = iss;
    p1_id = g;
    p1_c  = (^((a >> (2*g)) & 8'd3)) & (^((b >> (2*g)) & 8'd3));
    if (iss) begin
      mptr = g;
      n_ops++;
    end
    cyc();
  endtask

  initial begin : main
    logic [7:0] a2, b2;
    logic [3:0] exp_ab;
    int         cyc_cnt;
    a2     = 8'b10_11_01_10;
    b2     = 8'b10_10_00_01;
    exp_ab = 4'b1001;

    // Reset: outputs stay quiet even with every input asserted.
    rst_n = 1'b0;
    idle_in();
    cyc();
    bus.in_req_valid  = 4'hF;
    bus.in_req_b      = 8'hFF;
    bus.in_rand_valid = 1'b1;
    bus.in_rand_r     = 2'd3;
    #1;
    chk("rst_ready", 32'(bus.out_req_ready), 32'd0);
    chk("rst_rand_ready", 32'(bus.out_rand_ready), 32'd0);
    chk("rst_busy", 32'(bus.out_busy), 32'd0);
    chk("rst_res_valid", 32'(bus.out_res_valid), 32'd0);
    chk("rst_mul_b", 32'(bus.out_mul_b), 32'd0);
    cyc();
    rst_n = 1'b1;
    idle_in();
    cyc(); cyc(); cyc();

    // Single requests: b unmasked 0 then 1.
    single(1, 2'b01, 2'b11, 2'b10, 1'b1, 1'b0);
    single(1, 2'b01, 2'b10, 2'b01, 1'b0, 1'b1);

    // Reset one cycle after an issue: result discarded, outputs zero at once.
    bus.in_req_valid  = 4'b1000;
    bus.in_req_a      = 8'hFF;
    bus.in_req_b      = 8'hFF;
    bus.in_rand_valid = 1'b1;
    bus.in_rand_r     = 2'd1;
    bus.in_rand_p     = 1'b1;
    #1;
    chk("r5_ready", 32'(bus.out_req_ready), 32'h8);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("r5_ready_rst", 32'(bus.out_req_ready), 32'd0);
    chk("r5_rand_ready_rst", 32'(bus.out_rand_ready), 32'd0);
    chk("r5_mul_a_rst", 32'(bus.out_mul_a), 32'd0);
    chk("r5_mul_p_rst", 32'(bus.out_mul_p), 32'd0);
    chk("r5_mul_b_rst", 32'(bus.out_mul_b), 32'd0);
    chk("r5_mul_r_rst", 32'(bus.out_mul_r), 32'd0);
    chk("r5_busy_rst", 32'(bus.out_busy), 32'd0);
    chk("r5_res_id_rst", 32'(bus.out_res_id), 32'd0);
    chk("r5_res_c_rst", 32'(bus.out_res_c), 32'd0);
    cyc();
    #1;
    chk("r5_res_valid_rst", 32'(bus.out_res_valid), 32'd0);
    cyc();
    rst_n = 1'b1;
    idle_in();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("r5_res_valid_post", 32'(bus.out_res_valid), 32'd0);
      cyc();
    end

    // All four requesting every cycle: grants 0,1,2,3,0,... from reset.
    for (int k = 0; k < 10; k++) begin
      bus.in_enable     = 1'b1;
      bus.in_req_valid  = (k < 8) ? 4'hF : 4'h0;
      bus.in_req_a      = a2;
      bus.in_req_b      = b2;
      bus.in_rand_valid = 1'b1;
      bus.in_rand_r     = 2'(k);
      bus.in_rand_p     = 1'(k);
      #1;
      chk("rr_ready", 32'(bus.out_req_ready), (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
      if (k < 8) chk("rr_mul_b", 32'(bus.out_mul_b), 32'((b2 >> (2*(k % 4))) & 8'd3));
      if (k >= 1 && k <= 8) chk("rr_mul_a", 32'(bus.out_mul_a), 32'((a2 >> (2*((k-1) % 4))) & 8'd3));
      if (k >= 2) begin
        chk("rr_res_valid", 32'(bus.out_res_valid), 32'd1);
        chk("rr_res_id", 32'(bus.out_res_id), 32'((k - 2) % 4));
        chk("rr_res_c", 32'(^bus.out_res_c), 32'((exp_ab >> ((k - 2) % 4)) & 4'd1));
      end
      cyc();
    end
    idle_in();
    cyc();

    // Randomness starvation with req0 pending.
    bus.in_req_valid  = 4'b0001;
    bus.in_req_a      = 8'b10;
    bus.in_req_b      = 8'b11;
    bus.in_rand_valid = 1'b1;
    #1;
    chk("rs_ready_first", 32'(bus.out_req_ready), 32'h1);
    cyc();
    bus.in_rand_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("rs_ready_stall", 32'(bus.out_req_ready), 32'd0);
      chk("rs_rand_ready_stall", 32'(bus.out_rand_ready), 32'd0);
      chk("rs_busy", 32'(bus.out_busy), (k < 3) ? 32'd1 : 32'd0);
      if (k == 2) chk("rs_res_c", 32'(^bus.out_res_c), 32'd0);
      cyc();
    end
    bus.in_rand_valid = 1'b1;
    #1;
    chk("rs_ready_resume", 32'(bus.out_req_ready), 32'h1);
    chk("rs_rand_ready_resume", 32'(bus.out_rand_ready), 32'd1);
    cyc();
    idle_in();
    cyc(); cyc(); cyc();

    // Enable drops right after req2 issues: drains, no new issue.
    bus.in_req_valid  = 4'b0100;
    bus.in_req_a      = 8'b01_0000;
    bus.in_req_b      = 8'b01_0000;
    bus.in_rand_valid = 1'b1;
    #1;
    chk("en_ready_issue", 32'(bus.out_req_ready), 32'h4);
    cyc();
    bus.in_enable    = 1'b0;
    bus.in_req_valid = 4'b1100;
    #1;
    chk("en_ready_off", 32'(bus.out_req_ready), 32'd0);
    chk("en_rand_ready_off", 32'(bus.out_rand_ready), 32'd0);
    chk("en_mul_b_off", 32'(bus.out_mul_b), 32'd0);
    chk("en_mul_a", 32'(bus.out_mul_a), 32'b01);
    cyc();
    #1;
    chk("en_res_valid", 32'(bus.out_res_valid), 32'd1);
    chk("en_res_id", 32'(bus.out_res_id), 32'd2);
    chk("en_res_c", 32'(^bus.out_res_c), 32'd1);
    cyc();
    #1;
    chk("en_busy_t3", 32'(bus.out_busy), 32'd0);
    chk("en_res_valid_t3", 32'(bus.out_res_valid), 32'd0);
    cyc();

    // Fresh reset, then idle with live inputs: multiplier ports must stay zero.
    rst_n = 1'b0;
    idle_in();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    bus.in_req_valid  = 4'hF;
    bus.in_req_a      = 8'hFF;
    bus.in_req_b      = 8'hFF;
    bus.in_rand_valid = 1'b0;
    bus.in_rand_r     = 2'd3;
    bus.in_rand_p     = 1'b1;
    #1;
    chk("idle_mul_a", 32'(bus.out_mul_a), 32'd0);
    chk("idle_mul_b", 32'(bus.out_mul_b), 32'd0);
    chk("idle_mul_r", 32'(bus.out_mul_r), 32'd0);
    chk("idle_mul_p", 32'(bus.out_mul_p), 32'd0);
    chk("idle_ready", 32'(bus.out_req_ready), 32'd0);
    cyc();

    mptr    = 3;
    n_ops   = 0;
    p1_v    = 1'b0;
    p2_v    = 1'b0;
    p1_id   = 0;
    p2_id   = 0;
    p1_c    = 1'b0;
    p2_c    = 1'b0;
    cyc_cnt = 0;
    while (n_ops < 1000 && cyc_cnt < 5000) begin
      rand_cycle(1'b0);
      cyc_cnt++;
    end
    rand_cycle(1'b1);
    rand_cycle(1'b1);
    chk("rnd_op_count", 32'(n_ops), 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
